// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, 32x32 register file, load-use stall, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN selects a write-first register file (default read-first).
module decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic [31:0] npc,
   input  logic [31:0] notbranch,
   input  logic        flushD,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stallF,
   output logic        stallD,
   output logic        valid_out,
   output logic [6:0]  opcode_out,
   output logic [2:0]  funct3_out,
   output logic [6:0]  funct7_out,
   output logic [4:0]  rs1_out,
   output logic [4:0]  rs2_out,
   output logic [4:0]  rd_out,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic [31:0] imm_out,
   output logic [31:0] pc_out,
   output logic [31:0] notbranch_out
);

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] OP     = 7'b0110011;

   logic        primed_r;
   logic [31:0] regs_r [32];

   logic [6:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [31:0] imm_s;
   logic        uses_rs1_s;
   logic        uses_rs2_s;
   logic        hazard_s;
   logic        bubble_s;
   logic [31:0] rs1_rd_s;
   logic [31:0] rs2_rd_s;

   assign opcode_s = ir[6:0];
   assign rd_s     = ir[11:7];
   assign rs1_s    = ir[19:15];
   assign rs2_s    = ir[24:20];

   // Immediate generation, selected by opcode format
   always_comb begin
      imm_s = 32'd0;
      case (opcode_s)
         OP_IMM, LOAD, JALR: imm_s = {{20{ir[31]}}, ir[31:20]};
         STORE:              imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         BRANCH:             imm_s = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         LUI, AUIPC:         imm_s = {ir[31:12], 12'd0};
         JAL:                imm_s = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:            imm_s = 32'd0;
      endcase
   end

   // Source-operand usage and load-use hazard detection against the ID/EX register
   always_comb begin
      uses_rs1_s = 1'b1;
      uses_rs2_s = 1'b0;
      case (opcode_s)
         LUI, AUIPC, JAL:   uses_rs1_s = 1'b0;
         BRANCH, STORE, OP: uses_rs2_s = 1'b1;
         default:           uses_rs2_s = 1'b0;
      endcase
      if (valid_out && (opcode_out == LOAD) && (rd_out != 5'd0)) begin
         hazard_s = (uses_rs1_s && (rs1_s == rd_out)) || (uses_rs2_s && (rs2_s == rd_out));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign stallF   = hazard_s;
   assign stallD   = hazard_s;
   // Flush, hazard and the unprimed start-up cycle all collapse into a bubble
   assign bubble_s = flushD | hazard_s | ~primed_r;

   // Register-file read, optionally forwarding the same-cycle write-back
   always_comb begin
      rs1_rd_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
      rs2_rd_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_s)) begin
         rs1_rd_s = wb_data;
      end else begin
         rs1_rd_s = rs1_rd_s;
      end
      if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_s)) begin
         rs2_rd_s = wb_data;
      end else begin
         rs2_rd_s = rs2_rd_s;
      end
`endif
   end

   // Register file storage with write-back port; x0 is never written
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else if (wb_en && (wb_rd != 5'd0)) begin
         regs_r[wb_rd] <= wb_data;
      end
   end

   // Start-up flag: the first cycle out of reset is treated as a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         primed_r <= 1'b0;
      end else begin
         primed_r <= 1'b1;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk) begin
      if (reset || bubble_s) begin
         valid_out     <= 1'b0;
         opcode_out    <= OP_IMM;
         funct3_out    <= 3'd0;
         funct7_out    <= 7'd0;
         rs1_out       <= 5'd0;
         rs2_out       <= 5'd0;
         rd_out        <= 5'd0;
         rs1_data      <= 32'd0;
         rs2_data      <= 32'd0;
         imm_out       <= 32'd0;
         pc_out        <= RESET_PC;
         notbranch_out <= RESET_PC + 32'd4;
      end else begin
         valid_out     <= 1'b1;
         opcode_out    <= opcode_s;
         funct3_out    <= ir[14:12];
         funct7_out    <= ir[31:25];
         rs1_out       <= rs1_s;
         rs2_out       <= rs2_s;
         rd_out        <= rd_s;
         rs1_data      <= rs1_rd_s;
         rs2_data      <= rs2_rd_s;
         imm_out       <= imm_s;
         pc_out        <= npc;
         notbranch_out <= notbranch;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-computed from the ISA encodings.
module tb_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0000_8000;

   logic        clk = 1'b0;
   logic        reset, flushD, wb_en;
   logic [31:0] ir, npc, notbranch, wb_data;
   logic [4:0]  wb_rd;
   logic        stallF, stallD, valid_out;
   logic [6:0]  opcode_out, funct7_out;
   logic [2:0]  funct3_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [31:0] rs1_data, rs2_data, imm_out, pc_out, notbranch_out;

   int n_cmp = 0;
   int n_bad = 0;

   decode_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .ir(ir), .npc(npc), .notbranch(notbranch),
      .flushD(flushD), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .stallF(stallF), .stallD(stallD), .valid_out(valid_out),
      .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_out(imm_out),
      .pc_out(pc_out), .notbranch_out(notbranch_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flushD = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      ir = 32'h00500093; npc = 32'h100; notbranch = 32'h104;
      tick(); tick();
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid_out); end
      n_cmp++; if (opcode_out !== 7'h13) begin n_bad++; $display("FAIL rst_opcode got %h want 13", opcode_out); end
      n_cmp++; if ({rd_out, rs1_out, rs2_out, funct3_out, funct7_out} !== 25'd0) begin n_bad++; $display("FAIL rst_fields got %h want 0", {rd_out, rs1_out, rs2_out, funct3_out, funct7_out}); end
      n_cmp++; if ({imm_out, rs1_data, rs2_data} !== 96'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", {imm_out, rs1_data, rs2_data}); end
      n_cmp++; if (pc_out !== RST_PC || notbranch_out !== 32'h8004) begin n_bad++; $display("FAIL rst_pc got %h/%h want 8000/8004", pc_out, notbranch_out); end
      n_cmp++; if ({stallF, stallD} !== 2'b00) begin n_bad++; $display("FAIL rst_stall got %b want 00", {stallF, stallD}); end
      reset = 1'b0;
      tick();
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL unprimed_valid got %b want 0", valid_out); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || rd_out !== 5'd1 || imm_out !== 32'd5) begin n_bad++; $display("FAIL first_issue got v=%b rd=%0d imm=%h want 1/1/5", valid_out, rd_out, imm_out); end
      n_cmp++; if (pc_out !== 32'h100 || notbranch_out !== 32'h104) begin n_bad++; $display("FAIL first_pc got %h/%h want 100/104", pc_out, notbranch_out); end
   endtask

   task automatic test_immediates();
      ir = 32'hFE20AE23; tick();
      n_cmp++; if (imm_out !== 32'hFFFFFFFC || rs2_out !== 5'd2 || rs1_out !== 5'd1) begin n_bad++; $display("FAIL imm_s got %h rs2=%0d rs1=%0d want fffffffc/2/1", imm_out, rs2_out, rs1_out); end
      ir = 32'h000012B7; tick();
      n_cmp++; if (imm_out !== 32'h00001000 || rd_out !== 5'd5 || opcode_out !== 7'h37) begin n_bad++; $display("FAIL imm_u got %h rd=%0d op=%h want 1000/5/37", imm_out, rd_out, opcode_out); end
      ir = 32'hFFFFFFFF; tick();
      n_cmp++; if (imm_out !== 32'd0 || funct7_out !== 7'h7F) begin n_bad++; $display("FAIL imm_other got %h f7=%h want 0/7f", imm_out, funct7_out); end
   endtask

   task automatic test_load_use();
      ir = 32'h0000A103; npc = 32'h200; notbranch = 32'h204; tick();
      n_cmp++; if (valid_out !== 1'b1 || opcode_out !== 7'h03 || rd_out !== 5'd2 || funct3_out !== 3'd2) begin n_bad++; $display("FAIL lw_issue got v=%b op=%h rd=%0d f3=%0d", valid_out, opcode_out, rd_out, funct3_out); end
      ir = 32'h002081B3; npc = 32'h204; notbranch = 32'h208; #1;
      n_cmp++; if ({stallF, stallD} !== 2'b11) begin n_bad++; $display("FAIL lu_stall got %b want 11", {stallF, stallD}); end
      tick();
      n_cmp++; if (valid_out !== 1'b0 || rd_out !== 5'd0 || pc_out !== RST_PC) begin n_bad++; $display("FAIL lu_bubble got v=%b rd=%0d pc=%h want 0/0/8000", valid_out, rd_out, pc_out); end
      n_cmp++; if ({stallF, stallD} !== 2'b00) begin n_bad++; $display("FAIL lu_stall_clear got %b want 00", {stallF, stallD}); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || rs2_out !== 5'd2 || rd_out !== 5'd3) begin n_bad++; $display("FAIL lu_add got v=%b rs2=%0d rd=%0d want 1/2/3", valid_out, rs2_out, rd_out); end
      n_cmp++; if (pc_out !== 32'h204 || notbranch_out !== 32'h208) begin n_bad++; $display("FAIL lu_pc got %h/%h want 204/208", pc_out, notbranch_out); end
   endtask

   task automatic test_flush();
      ir = 32'h00500093; npc = 32'h300; notbranch = 32'h304; flushD = 1'b1; tick();
      n_cmp++; if (valid_out !== 1'b0 || rd_out !== 5'd0) begin n_bad++; $display("FAIL flush got v=%b rd=%0d want 0/0", valid_out, rd_out); end
      flushD = 1'b0; ir = 32'h0000A103; tick();
      ir = 32'h002081B3; flushD = 1'b1; #1;
      n_cmp++; if ({stallF, stallD} !== 2'b11) begin n_bad++; $display("FAIL flush_hz_stall got %b want 11", {stallF, stallD}); end
      tick(); flushD = 1'b0;
      n_cmp++; if (valid_out !== 1'b0 || {stallF, stallD} !== 2'b00) begin n_bad++; $display("FAIL flush_hz_bubble got v=%b st=%b want 0/00", valid_out, {stallF, stallD}); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || rd_out !== 5'd3) begin n_bad++; $display("FAIL flush_hz_issue got v=%b rd=%0d want 1/3", valid_out, rd_out); end
   endtask

   task automatic test_writeback();
      logic [31:0] exp_same;
`ifdef DECODE_WB_BYPASS_EN
      exp_same = 32'hDEADBEEF;
`else
      exp_same = 32'd0;
`endif
      ir = 32'h00018213; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF; tick();
      n_cmp++; if (rs1_out !== 5'd3 || rs1_data !== exp_same) begin n_bad++; $display("FAIL wb_same got rs1=%0d data=%h want 3/%h", rs1_out, rs1_data, exp_same); end
      wb_en = 1'b0; tick();
      n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wb_later got %h want deadbeef", rs1_data); end
      ir = 32'h00500093; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678; tick();
      wb_en = 1'b0; tick();
      n_cmp++; if (rs1_data !== 32'd0 || rs1_out !== 5'd0) begin n_bad++; $display("FAIL x0_read got %h want 0", rs1_data); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; tick();
      n_cmp++; if (valid_out !== 1'b0 || pc_out !== RST_PC || notbranch_out !== 32'h8004 || opcode_out !== 7'h13) begin n_bad++; $display("FAIL mid_rst got v=%b pc=%h nb=%h op=%h", valid_out, pc_out, notbranch_out, opcode_out); end
      n_cmp++; if ({stallF, stallD} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_stall got %b want 00", {stallF, stallD}); end
      reset = 1'b0; ir = 32'h00018213; tick();
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_unprimed got %b want 0", valid_out); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || rs1_data !== 32'd0) begin n_bad++; $display("FAIL mid_rf_clear got v=%b x3=%h want 1/0", valid_out, rs1_data); end
   endtask

   initial begin
      test_reset();
      test_immediates();
      test_load_use();
      test_flush();
      test_writeback();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
